// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: round-robin grant, request/ack handshake
// on both sides, and an optional wait timeout that aborts a stalled access.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       sel_o,
  output logic [1:0] gnt_o,
  output logic       mem_req_o,
  input  logic       mem_ack_i,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             mem_req_q, mem_req_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win;
  logic             to_hit;

  // On a tie the requester that was not served last wins.
  assign win    = (req0_i && req1_i) ? ~last_q : req1_i;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    mem_req_d = mem_req_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        gnt_d     = 2'b00;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        if (req0_i || req1_i) begin
          state_d   = GRANT;
          sel_d     = win;
          gnt_d     = win ? 2'b10 : 2'b01;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      GRANT: begin
        // Requester inputs are ignored here; only memory or the timeout ends the access.
        if (mem_ack_i || to_hit) begin
          state_d   = DONE;
          ack0_d    = ~sel_q;
          ack1_d    = sel_q;
          err_d     = ~mem_ack_i;
          mem_req_d = 1'b0;
          gnt_d     = 2'b00;
          last_d    = sel_q;
          busy_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        gnt_d     = 2'b00;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = 2'b00;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      gnt_q     <= 2'b00;
      mem_req_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      mem_req_q <= mem_req_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign sel_o     = sel_q;
  assign gnt_o     = gnt_q;
  assign mem_req_o = mem_req_q;
  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: requester 0 is instruction fetch, requester 1 is data access.
- Drives the select line of the 2-to-1 muxes that steer address, write data and control onto the shared port.
- Sequences each access with a request/acknowledge handshake on both sides.
- Uses round-robin fairness and a bounded wait, so a stalled memory cannot hang the pipeline.

Parameters:
- TIMEOUT, 16, max GRANT cycles without mem_ack_i before the access is aborted; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req0_i  input  1  requester 0 (fetch) access request; level, held until ack0_o.
- req1_i  input  1  requester 1 (data) access request; level, held until ack1_o.
- ack0_o  output  1  one-cycle completion pulse to requester 0.
- ack1_o  output  1  one-cycle completion pulse to requester 1.
- sel_o  output  1  mux select: 0 routes requester 0 (data0_i side), 1 routes requester 1 (data1_i side).
- gnt_o  output  2  one-hot current grant; bit n = requester n owns the port.
- mem_req_o  output  1  request to memory; high for the whole GRANT state.
- mem_ack_i  input  1  memory completion, sampled only in GRANT.
- busy_o  output  1  high in GRANT and DONE.
- err_o  output  1  one-cycle pulse coincident with the ack pulse when the access timed out.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, sel_o=0, gnt_o=00, mem_req_o=0, ack0_o=0, ack1_o=0, err_o=0, busy_o=0, wait counter=0.
  - Priority pointer last=1 on reset, so requester 0 wins the first tie.
- Reset has priority over every transition. Asserted mid-transaction it aborts the access; all outputs take reset values at the next edge; no ack or err pulse is produced.
- States: IDLE, GRANT, DONE.
- IDLE:
  - No request: stay in IDLE; sel_o holds its last value (no toggling while idle).
  - Exactly one request: grant it.
  - Both requesting: grant the requester not equal to last.
  - On grant, at the next edge: state=GRANT, sel_o=winner index, gnt_o=one-hot winner, mem_req_o=1, busy_o=1, counter=0.
- GRANT:
  - sel_o and gnt_o are stable for the whole state; requester inputs are ignored (dropping req early does not cancel the access).
  - mem_ack_i=1: next state DONE; ack of the granted requester=1; mem_req_o=0; last=granted index.
  - mem_ack_i=0 and TIMEOUT!=0 and counter==TIMEOUT-1: next state DONE; ack pulse and err_o=1; mem_req_o=0; last=granted index.
  - Otherwise: counter increments; state stays GRANT.
- DONE:
  - Exactly one cycle.
  - Ack pulse (and err_o if timed out) is visible.
  - gnt_o=00; sel_o unchanged.
  - No arbitration, so a requester still holding req during the ack cycle is not re-granted.
  - Next state IDLE; ack and err return to 0.
- Latency:
  - Request sampled at edge E → mem_req_o high at E+1.
  - mem_ack_i sampled at edge F → ack at F+1.
  - Minimum request-to-ack is 2 cycles; back-to-back grants are 3 cycles apart (IDLE, GRANT, DONE).
- mem_ack_i outside GRANT is ignored.
- ack0_o and ack1_o are never high together.
- gnt_o is never 11.

Test Plan:
- Reset, then req0_i=1; mem_ack_i=1 on the first GRANT cycle → mem_req_o=1, sel_o=0, gnt_o=01 for 1 cycle; ack0_o pulses exactly 1 cycle, 2 cycles after req sampled; err_o=0.
- req0_i and req1_i held high continuously, mem_ack_i=1 always → grants alternate 0,1,0,1 (requester 0 first after reset); sel_o follows; an ack pulse every 3 cycles.
- req1_i=1, mem_ack_i=0 for TIMEOUT=16 cycles → mem_req_o high exactly 16 cycles; then ack1_o=1 and err_o=1 together for 1 cycle; state returns to IDLE.
- Grant to requester 1, then req1_i dropped mid-GRANT, mem_ack_i after 4 cycles → access completes; ack1_o pulses; sel_o stays 1 throughout GRANT and DONE.
- rst_i asserted during the 3rd GRANT cycle → next edge: mem_req_o=0, gnt_o=00, sel_o=0; no ack pulse; the next tied request goes to requester 0.
- mem_ack_i pulsed while IDLE, with no request → no state change and no ack pulse.
